// File: rtl/run_monitor_pkg.sv
// Shared types and helpers for the run supervisor and its capture FIFO.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) < depth) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with synchronous reset and flush; wrap-around
// pointers plus a separate occupancy counter.
module sync_fifo
    import run_monitor_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [ptr_width(DEPTH):0]    count,
    output logic                         wr_accept,
    output logic                         wr_drop
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW:0]       count_r;
    logic              pop_s;

    assign empty = (count_r == {(PW + 1){1'b0}});
    assign full  = (count_r == FULL_COUNT);
    assign count = count_r;

    // Head is masked while empty so stale storage never leaks out.
    assign rd_data = empty ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];

    // Flush takes priority over both ports; a pop frees the slot a full push needs.
    always_comb begin
        pop_s     = 1'b0;
        wr_accept = 1'b0;
        wr_drop   = 1'b0;
        if (flush) begin
            pop_s     = 1'b0;
            wr_accept = 1'b0;
            wr_drop   = 1'b0;
        end else begin
            pop_s     = rd_en && !empty;
            wr_accept = wr_en && (!full || pop_s);
            wr_drop   = wr_en && full && !pop_s;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW + 1){1'b0}};
        end else begin
            if (wr_accept) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({wr_accept, pop_s})
                2'b10:   count_r <= count_r + (PW + 1)'(1);
                2'b01:   count_r <= count_r - (PW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are only observable through a non-zero count.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run supervisor: arms on start, counts RUN cycles, captures to_mem words into
// a readback FIFO and ends the run on halt or on a cycle timeout.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_valid,
    input  logic              halt,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              overflow,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  word_count
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int               PW           = ptr_width(FIFO_DEPTH);

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cycle_count_r;
    logic [CNT_W-1:0]  word_count_r;
    logic              overflow_r;
    logic              arm_s;
    logic              push_s;
    logic              accept_s;
    logic              drop_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [PW:0]       fifo_count_s;
    logic              fifo_unused_s;

    // A start outside RUN re-arms; inside RUN it is ignored.
    assign arm_s  = start && (state_r != RUN);
    assign push_s = mem_valid && (state_r == RUN);

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (arm_s),
        .wr_en     (push_s),
        .wr_data   (mem_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .wr_accept (accept_s),
        .wr_drop   (drop_s)
    );

    assign fifo_unused_s = fifo_full_s ^ (^fifo_count_s);

    // Next-state decode; halt outranks the timeout in the same cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE, TIMEOUT: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (halt) begin
                    state_s = DONE;
                end else if (cycle_count_r == TIMEOUT_LAST) begin
                    state_s = TIMEOUT;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, run counters and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cycle_count_r <= {CNT_W{1'b0}};
            word_count_r  <= {CNT_W{1'b0}};
            overflow_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            if (arm_s) begin
                cycle_count_r <= {CNT_W{1'b0}};
                word_count_r  <= {CNT_W{1'b0}};
                overflow_r    <= 1'b0;
            end else begin
                if (state_r == RUN) begin
                    cycle_count_r <= cycle_count_r + CNT_W'(1);
                end
                if (accept_s && (word_count_r != {CNT_W{1'b1}})) begin
                    word_count_r <= word_count_r + CNT_W'(1);
                end
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    assign rd_valid    = !fifo_empty_s;
    assign busy        = (state_r == RUN);
    assign done        = (state_r == DONE);
    assign timeout     = (state_r == TIMEOUT);
    assign overflow    = overflow_r;
    assign cycle_count = cycle_count_r;
    assign word_count  = word_count_r;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: expected FIFO words go into a scoreboard
// queue that a separate monitor checks on every pop; status is checked inline.
module tb_run_monitor;

    localparam int DATA_W  = 16;
    localparam int DEPTH   = 4;
    localparam int TMO     = 50;
    localparam int CNT_W   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [DATA_W-1:0] mem_data = 16'h0000;
    logic              mem_valid = 1'b0;
    logic              halt = 1'b0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              overflow;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  word_count;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_word;

    run_monitor #(
        .DATA_W         (DATA_W),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mem_data    (mem_data),
        .mem_valid   (mem_valid),
        .halt        (halt),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .overflow    (overflow),
        .cycle_count (cycle_count),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        chk({tag, "_rd_data"}, {16'd0, rd_data}, 32'd0);
        chk({tag, "_cycle_count"}, cycle_count, 32'd0);
        chk({tag, "_word_count"}, word_count, 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Pop until empty (bounded), then confirm the scoreboard drained too.
    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (rd_valid && guard < 20) begin
            rd_en = 1'b1;
            step();
            guard++;
        end
        rd_en = 1'b0;
        chk({tag, "_drain_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        chk({tag, "_drain_queue"}, exp_q.size(), 32'd0);
    endtask

    // Scoreboard monitor: every accepted pop must match the oldest expected word.
    always @(negedge clk) begin
        if (rd_en && rd_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fifo_pop: got %h with no word expected at %0t", rd_data, $time);
            end else begin
                exp_word = exp_q.pop_front();
                if (rd_data !== exp_word) begin
                    n_fail++;
                    $display("FAIL fifo_pop: got %h expected %h at %0t", rd_data, exp_word, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset then idle
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        rd_en = 1'b1;
        repeat (3) step();
        rd_en = 1'b0;
        chk("idle_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("idle_overflow", {31'd0, overflow}, 32'd0);

        // Basic run; the word offered in the start cycle must be ignored
        start = 1'b1;
        mem_valid = 1'b1;
        mem_data = 16'h7777;
        step();
        start = 1'b0;
        mem_valid = 1'b0;
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_cycle0", cycle_count, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            mem_valid = (k == 2) || (k == 3) || (k == 5);
            mem_data  = (k == 2) ? 16'h0011 : (k == 3) ? 16'h0022 : 16'h0033;
            halt      = (k == 10);
            if (mem_valid) begin
                exp_q.push_back(mem_data);
            end
            step();
            chk("run_rd_valid_latency", {31'd0, rd_valid}, {31'd0, (k >= 2)});
            chk("run_cycle_count", cycle_count, k);
        end
        mem_valid = 1'b0;
        halt = 1'b0;
        chk("basic_done", {31'd0, done}, 32'd1);
        chk("basic_busy", {31'd0, busy}, 32'd0);
        chk("basic_cycle_count", cycle_count, 32'd10);
        chk("basic_word_count", word_count, 32'd3);
        drain("basic");

        // Timeout after exactly TMO run cycles; later halt has no effect
        pulse_start();
        repeat (TMO - 1) step();
        chk("tmo_not_yet", {31'd0, timeout}, 32'd0);
        chk("tmo_busy", {31'd0, busy}, 32'd1);
        step();
        chk("tmo_timeout", {31'd0, timeout}, 32'd1);
        chk("tmo_cycle_count", cycle_count, TMO);
        halt = 1'b1;
        step();
        halt = 1'b0;
        step();
        chk("tmo_hold", {31'd0, timeout}, 32'd1);
        chk("tmo_halt_ignored", {31'd0, done}, 32'd0);
        chk("tmo_cycle_frozen", cycle_count, TMO);

        // Overflow: six pushes into four slots, no pops
        pulse_start();
        for (int i = 1; i <= 6; i++) begin
            mem_valid = 1'b1;
            mem_data  = 16'(i);
            if (i <= DEPTH) begin
                exp_q.push_back(mem_data);
            end
            step();
        end
        mem_valid = 1'b0;
        chk("ovf_overflow", {31'd0, overflow}, 32'd1);
        chk("ovf_word_count", word_count, 32'd4);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("ovf_done", {31'd0, done}, 32'd1);
        drain("ovf");

        // Full boundary: popping from the push that first meets a full FIFO
        pulse_start();
        chk("full_flag_cleared", {31'd0, overflow}, 32'd0);
        for (int i = 1; i <= 6; i++) begin
            mem_valid = 1'b1;
            mem_data  = 16'(i);
            rd_en     = (i >= 5);
            exp_q.push_back(mem_data);
            step();
        end
        mem_valid = 1'b0;
        chk("full_no_overflow", {31'd0, overflow}, 32'd0);
        chk("full_word_count", word_count, 32'd6);
        halt = 1'b1;
        step();
        halt = 1'b0;
        drain("full");

        // Halt and push in the final timeout cycle: halt wins, word captured
        pulse_start();
        repeat (TMO - 1) step();
        chk("sim_cycle_last", cycle_count, TMO - 1);
        halt = 1'b1;
        mem_valid = 1'b1;
        mem_data = 16'hBEEF;
        exp_q.push_back(mem_data);
        step();
        halt = 1'b0;
        mem_valid = 1'b0;
        chk("sim_done", {31'd0, done}, 32'd1);
        chk("sim_timeout", {31'd0, timeout}, 32'd0);
        chk("sim_cycle_count", cycle_count, TMO);
        chk("sim_word_count", word_count, 32'd1);
        drain("sim");

        // Restart from DONE with two words left unread and overflow set
        pulse_start();
        for (int i = 1; i <= 6; i++) begin
            mem_valid = 1'b1;
            mem_data  = 16'hA000 + 16'(i);
            if (i <= 2) begin
                exp_q.push_back(mem_data);
            end
            step();
        end
        mem_valid = 1'b0;
        halt = 1'b1;
        step();
        halt = 1'b0;
        rd_en = 1'b1;
        step();
        step();
        rd_en = 1'b0;
        chk("restart_left_unread", {31'd0, rd_valid}, 32'd1);
        chk("restart_overflow_before", {31'd0, overflow}, 32'd1);
        pulse_start();
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_flushed", {31'd0, rd_valid}, 32'd0);
        chk("restart_rd_data", {16'd0, rd_data}, 32'd0);
        chk("restart_cycle_count", cycle_count, 32'd0);
        chk("restart_word_count", word_count, 32'd0);
        chk("restart_overflow", {31'd0, overflow}, 32'd0);

        // Reset in the middle of a run that has data and an overflow
        for (int i = 1; i <= 6; i++) begin
            mem_valid = 1'b1;
            mem_data  = 16'hC000 + 16'(i);
            step();
        end
        mem_valid = 1'b0;
        chk("midrst_overflow_before", {31'd0, overflow}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("midrst");

        step();
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
Synthesisable run supervisor for the matrix-multiply processor. It replaces the fixed wall-clock stop with a real supervisor.
- Arms on a start pulse and counts run cycles.
- Captures every word the processor drives onto its to_mem bus into a readback FIFO.
- Ends the run on processor halt or on a parametrised cycle timeout.
- Sits beside the processor top; a host (bench or debug UART) drains the FIFO.

Parameters:
DATA_W, 16, width of the processor to_mem word
FIFO_DEPTH, 16, capture FIFO entries; power of two, >=2
TIMEOUT_CYCLES, 2000000, run cycles before forced stop; >=2
CNT_W, 32, width of cycle_count; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: clear and begin a run
mem_data  in  DATA_W  processor to_mem word
mem_valid  in  1  mem_data is a new word this cycle
halt  in  1  processor finished (level or pulse)
rd_en  in  1  host pop request
rd_data  out  DATA_W  FIFO head (first-word-fall-through)
rd_valid  out  1  FIFO non-empty
busy  out  1  state == RUN
done  out  1  state == DONE
timeout  out  1  state == TIMEOUT
overflow  out  1  sticky: a capture was dropped this run
cycle_count  out  CNT_W  cycles spent in RUN this run
word_count  out  CNT_W  words accepted into FIFO this run (saturating)

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0 and the FIFO is empty (rd_valid=0, rd_data=0).
  - Reset mid-run aborts immediately; there are no partial effects next cycle.
- FSM states: IDLE, RUN, DONE, TIMEOUT.
  - IDLE/DONE/TIMEOUT + start: next cycle RUN.
    - cycle_count=0, word_count=0, overflow=0, FIFO flushed.
    - mem_valid in the start cycle is ignored.
  - RUN + start: ignored.
  - RUN + halt: next cycle DONE.
  - RUN, no halt, cycle_count==TIMEOUT_CYCLES-1: next cycle TIMEOUT.
  - Halt and timeout in the same cycle: halt wins (DONE).
  - DONE/TIMEOUT hold until start or rst.
- cycle_count:
  - Increments by 1 each cycle in RUN, so it reads 1 the cycle after entering RUN.
  - Freezes outside RUN.
  - Final value equals the number of RUN cycles, including the halt cycle.
- Capture:
  - In RUN, mem_valid=1 pushes mem_data.
  - Push in the halt cycle is still captured.
  - No capture outside RUN.
- FIFO is first-word-fall-through.
  - rd_valid rises the cycle after the first push (1-cycle latency).
  - rd_en with rd_valid=1 pops; rd_data shows the next entry the following cycle.
  - rd_en when empty is ignored, with no underflow side effect.
  - Pops are allowed in every state.
- Full FIFO:
  - A push without a same-cycle pop is dropped; overflow is set (sticky until next start/rst) and word_count does not increment.
  - Push and pop in the same cycle when full: both happen, no overflow.
  - Push and pop in the same cycle when empty: the push is stored and rd_valid rises next cycle.
- word_count: +1 per accepted push; saturates at all-ones.
- Pointers: log2(FIFO_DEPTH)-bit wrap-around plus a separate occupancy count of log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package run_monitor_pkg: state enum/localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2, TIMEOUT=2'd3) and the clog2-derived pointer width function.
- Sub-module sync_fifo (DATA_W, DEPTH; FWFT, synchronous reset, flush input, full/empty/count outputs).
- The FSM and counters stay in run_monitor.

Test Plan:
- Reset then idle: rst high 2 cycles -> all outputs 0; rd_en pulses leave rd_valid=0 and overflow=0.
- Basic run:
  - Stimulus: start, then mem_valid with 0x0011, 0x0022, 0x0033 on RUN cycles 2, 3, 5; halt on cycle 10.
  - Response: done=1, busy=0, cycle_count=10, word_count=3; popping yields 0x0011, 0x0022, 0x0033, then rd_valid=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=50, start, no halt.
  - Response: timeout=1 after exactly 50 RUN cycles, cycle_count=50; a halt asserted afterwards has no effect.
- Overflow and full boundary:
  - Stimulus: FIFO_DEPTH=4, 6 consecutive pushes 0x0001..0x0006, no pops.
  - Response: overflow=1, word_count=4, FIFO holds 0x0001..0x0004.
  - Repeat with rd_en held from the 4th push: no overflow.
- Simultaneous events:
  - Stimulus: halt and mem_valid 0xBEEF in the cycle where cycle_count==TIMEOUT_CYCLES-1.
  - Response: state DONE, 0xBEEF captured.
- Restart and mid-run reset:
  - Stimulus: in DONE with 2 words left unread, start.
  - Response: FIFO flushed, counters 0, overflow 0.
  - Stimulus: rst during RUN.
  - Response: IDLE next cycle with all outputs 0.
